mm2fifo_reader: RTL
===================

Name: mm2fifo_reader

Overview:
AXI4 burst-read master that fetches image frames from a memory frame buffer and pushes them into a write-side FIFO. It is the read-path counterpart of the stream-to-memory writer and feeds the video output pipeline. Frames are read starting at base_addr, one fixed-length burst at a time. Each burst is issued only when the FIFO has room for all of its beats.

Parameters:
C_DATACOUNT_BITS, 12, width of FIFO wr_data_count
C_FIFO_DEPTH, 2048, FIFO depth in words; free space = C_FIFO_DEPTH - wr_data_count
C_M_AXI_BURST_LEN, 16, beats per burst (1,2,4..256)
C_M_AXI_ID_WIDTH, 1, ARID/RID width
C_M_AXI_ADDR_WIDTH, 32, address width
C_M_AXI_DATA_WIDTH, 32, data width (bits)
C_IMG_WBITS, 12, image width bits
C_IMG_HBITS, 12, image height bits
C_PIXEL_WIDTH, 8, pixel bits; bytes/pixel = 1 (<=8), 2 (<=16), else 4

Ports:
M_AXI_ACLK  in  1  sole clock
M_AXI_ARESET  in  1  asynchronous, active-high reset
soft_resetn  in  1  low = stop after current burst
resetting  out  1  high while hard/soft reset is in effect or a burst is draining
img_width  in  C_IMG_WBITS  pixels per line
img_height  in  C_IMG_HBITS  lines per frame
base_addr  in  C_M_AXI_ADDR_WIDTH  frame buffer start, sampled at frame start
frame_pulse  out  1  one-cycle pulse when the first burst of a frame is issued
dout  out  C_M_AXI_DATA_WIDTH  FIFO write data (= RDATA)
sof  out  1  FIFO sideband, high on first word of a frame
wr_en  out  1  FIFO write strobe
full  in  1  FIFO full
wr_data_count  in  C_DATACOUNT_BITS  FIFO occupancy
M_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARLOCK/ARCACHE/ARPROT/ARQOS  out  std  AR channel
M_AXI_ARVALID  out  1 ; M_AXI_ARREADY  in  1
M_AXI_RID  in  ID ; M_AXI_RDATA  in  DATA ; M_AXI_RRESP  in  2 ; M_AXI_RLAST  in  1 ; M_AXI_RVALID  in  1
M_AXI_RREADY  out  1

Behaviour:
- Reset (async, M_AXI_ARESET=1): state IDLE; ARVALID, RREADY, wr_en, sof, frame_pulse = 0; araddr = 0; col/row idx = 0 (final_data=1); resetting = 1.
- Constants: ARLEN = BURST_LEN-1; ARSIZE = log2(DATA_WIDTH/8); ARBURST = INCR; ARCACHE = 4'b0010; ARID, ARLOCK, ARPROT, ARQOS = 0.
- Only one burst is outstanding at a time.
- State IDLE -> ADDR when soft_resetn=1 and (C_FIFO_DEPTH - wr_data_count) >= BURST_LEN. On this transition:
  - If final_data, araddr <= base_addr, col/row reload to (img_width - pixels_per_word, img_height-1), and frame_pulse fires.
  - Otherwise araddr <= araddr + BURST_LEN*DATA_WIDTH/8.
- ADDR: ARVALID=1; stays high until ARREADY is sampled, then -> DATA. The address is stable while ARVALID is high.
- DATA: RREADY = ~full (normal) or 1 (draining). wr_en = RVALID & RREADY & ~draining.
  - Each accepted beat decrements col by pixels_per_word; when col=0 it reloads and decrements row; at col=row=0 both hold.
  - sof=1 on the first accepted beat after a frame-start burst is issued.
  - RLAST accepted -> IDLE.
- Bursts never straddle frames. Frame size must be an integral multiple of the burst size.
- RLAST arriving early or late relative to the internal beat count is ignored; RLAST governs the state transition.
- Soft reset:
  - A soft_resetn falling edge while in ADDR/DATA sets draining. Remaining beats are accepted and discarded (wr_en=0), and the block returns to IDLE.
  - In IDLE, col/row are forced to 0 so the next frame restarts at base_addr.
  - resetting = M_AXI_ARESET | draining | ~soft_resetn.
- Hard reset mid-burst aborts immediately. The interconnect is reset by the same signal.

Optional Feature:
MM2FIFO_RRESP_CHECK_EN:
- Defined: adds output rresp_err (1 bit), set when an accepted beat has RRESP[1]=1 and cleared at the next frame_pulse. Errored beats are still written.
- Undefined: port absent and RRESP ignored.

Decomposition:
- Package mm2fifo_pkg: state enum (IDLE, ADDR, DATA), the clogb2 and cupperbytes functions, and the AXI constant encodings (INCR, CACHE).
- One sub-module, mm2fifo_frame_cnt, holds the col/row counter, final_data and the sof flag.

Test Plan:
- 64x2 image, 8-bit pixels, 32-bit data, BURST_LEN=16, base 0x1000_0000: ARADDR sequence 0x1000_0000, 0x1000_0040; then back to 0x1000_0000; frame_pulse on the 1st and 3rd AR; sof on beats 0 and 32.
- wr_data_count = DEPTH-15: no ARVALID; drop the count to DEPTH-16 -> ARVALID next cycle.
- ARREADY held low for 5 cycles: ARVALID and ARADDR remain stable; a single handshake occurs.
- full asserted for 3 cycles mid-burst: RREADY=0 for those cycles; no beat is lost and there are exactly 16 wr_en pulses.
- soft_resetn dropped after beat 4: beats 5-15 are accepted with wr_en=0 and resetting=1; after re-enable, ARADDR=base_addr with frame_pulse.
- RRESP=2'b10 on beat 3 (macro defined): rresp_err=1 until the next frame_pulse.

Source files
------------

// File: rtl/mm2fifo_pkg.sv
// Shared types, AXI encodings and elaboration-time helpers for the mm2fifo reader.
package mm2fifo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [3:0] AXI_CACHE_MOD  = 4'b0010;

    function automatic int clogb2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    // Pixels are packed at 1, 2 or 4 bytes each.
    function automatic int cupperbytes(input int bits);
        if (bits <= 8) begin
            return 1;
        end else if (bits <= 16) begin
            return 2;
        end else begin
            return 4;
        end
    endfunction

endpackage

// File: rtl/mm2fifo_frame_cnt.sv
// Column/row position tracker for the frame being read; flags frame end and the first word of a frame.
module mm2fifo_frame_cnt
    import mm2fifo_pkg::*;
#(
    parameter int C_IMG_WBITS    = 12,
    parameter int C_IMG_HBITS    = 12,
    parameter int C_PIX_PER_WORD = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   clear,
    input  logic                   beat,
    input  logic [C_IMG_WBITS-1:0] img_width,
    input  logic [C_IMG_HBITS-1:0] img_height,
    output logic                   final_data,
    output logic                   sof
);

    localparam logic [C_IMG_WBITS-1:0] PPW = C_IMG_WBITS'(C_PIX_PER_WORD);

    logic [C_IMG_WBITS-1:0] col_r;
    logic [C_IMG_HBITS-1:0] row_r;
    logic                   sof_r;

    // Position update: clear wins over a frame reload, which wins over a beat advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= '0;
            row_r <= '0;
            sof_r <= 1'b0;
        end else if (clear) begin
            col_r <= '0;
            row_r <= '0;
            sof_r <= 1'b0;
        end else if (load) begin
            col_r <= img_width - PPW;
            row_r <= img_height - C_IMG_HBITS'(1);
            sof_r <= 1'b1;
        end else if (beat) begin
            sof_r <= 1'b0;
            if (col_r != '0) begin
                col_r <= col_r - PPW;
            end else if (row_r != '0) begin
                col_r <= img_width - PPW;
                row_r <= row_r - C_IMG_HBITS'(1);
            end else begin
                col_r <= col_r;
                row_r <= row_r;
            end
        end else begin
            sof_r <= sof_r;
        end
    end

    assign final_data = (col_r == '0) && (row_r == '0);
    assign sof        = sof_r & beat;

endmodule

// File: rtl/mm2fifo_reader.sv
// AXI4 burst-read master streaming a memory frame buffer into a FIFO, one burst in flight.
// Optional: define MM2FIFO_RRESP_CHECK_EN to add the sticky rresp_err output.
module mm2fifo_reader
    import mm2fifo_pkg::*;
#(
    parameter int C_DATACOUNT_BITS   = 12,
    parameter int C_FIFO_DEPTH       = 2048,
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_IMG_WBITS        = 12,
    parameter int C_IMG_HBITS        = 12,
    parameter int C_PIXEL_WIDTH      = 8
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESET,
    input  logic                          soft_resetn,
    output logic                          resetting,
`ifdef MM2FIFO_RRESP_CHECK_EN
    output logic                          rresp_err,
`endif
    input  logic [C_IMG_WBITS-1:0]        img_width,
    input  logic [C_IMG_HBITS-1:0]        img_height,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
    output logic                          frame_pulse,
    output logic [C_M_AXI_DATA_WIDTH-1:0] dout,
    output logic                          sof,
    output logic                          wr_en,
    input  logic                          full,
    input  logic [C_DATACOUNT_BITS-1:0]   wr_data_count,
    output logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_ARID,
    output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
    output logic [7:0]                    M_AXI_ARLEN,
    output logic [2:0]                    M_AXI_ARSIZE,
    output logic [1:0]                    M_AXI_ARBURST,
    output logic                          M_AXI_ARLOCK,
    output logic [3:0]                    M_AXI_ARCACHE,
    output logic [2:0]                    M_AXI_ARPROT,
    output logic [3:0]                    M_AXI_ARQOS,
    output logic                          M_AXI_ARVALID,
    input  logic                          M_AXI_ARREADY,
    input  logic [C_M_AXI_ID_WIDTH-1:0]   M_AXI_RID,
    input  logic [C_M_AXI_DATA_WIDTH-1:0] M_AXI_RDATA,
    input  logic [1:0]                    M_AXI_RRESP,
    input  logic                          M_AXI_RLAST,
    input  logic                          M_AXI_RVALID,
    output logic                          M_AXI_RREADY
);

    localparam int BYTES_PER_WORD = C_M_AXI_DATA_WIDTH / 8;
    localparam int PIX_PER_WORD   = BYTES_PER_WORD / cupperbytes(C_PIXEL_WIDTH);
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] BURST_BYTES =
        C_M_AXI_ADDR_WIDTH'(C_M_AXI_BURST_LEN * BYTES_PER_WORD);

    state_t                        state_r;
    logic                          arvalid_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0] araddr_r;
    logic                          frame_pulse_r;
    logic                          draining_r;

    int   free_space_s;
    logic space_ok_s;
    logic start_s;
    logic frame_start_s;
    logic drain_s;
    logic rready_s;
    logic accept_s;
    logic beat_s;
    logic clear_s;
    logic final_data_s;
    logic unused_s;

    // Issue/accept decisions; a soft reset taking effect mid-burst discards beats at once.
    always_comb begin
        free_space_s  = C_FIFO_DEPTH - int'(wr_data_count);
        space_ok_s    = (free_space_s >= C_M_AXI_BURST_LEN);
        start_s       = (state_r == IDLE) && soft_resetn && space_ok_s;
        frame_start_s = start_s && final_data_s;
        drain_s       = draining_r | ((state_r != IDLE) & ~soft_resetn);
        if (state_r == DATA) begin
            rready_s = drain_s | ~full;
        end else begin
            rready_s = 1'b0;
        end
        accept_s = M_AXI_RVALID & rready_s;
        beat_s   = accept_s & ~drain_s;
        clear_s  = (state_r == IDLE) & ~soft_resetn;
    end

    // Burst sequencer: IDLE waits for FIFO room, ADDR holds the request, DATA runs until RLAST.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_r       <= IDLE;
            arvalid_r     <= 1'b0;
            araddr_r      <= '0;
            frame_pulse_r <= 1'b0;
            draining_r    <= 1'b0;
        end else begin
            frame_pulse_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    draining_r <= 1'b0;
                    if (start_s) begin
                        state_r       <= ADDR;
                        arvalid_r     <= 1'b1;
                        frame_pulse_r <= final_data_s;
                        araddr_r      <= final_data_s ? base_addr : araddr_r + BURST_BYTES;
                    end
                end
                ADDR: begin
                    if (!soft_resetn) begin
                        draining_r <= 1'b1;
                    end
                    if (M_AXI_ARREADY) begin
                        arvalid_r <= 1'b0;
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (!soft_resetn) begin
                        draining_r <= 1'b1;
                    end
                    if (accept_s && M_AXI_RLAST) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    arvalid_r <= 1'b0;
                end
            endcase
        end
    end

    mm2fifo_frame_cnt #(
        .C_IMG_WBITS   (C_IMG_WBITS),
        .C_IMG_HBITS   (C_IMG_HBITS),
        .C_PIX_PER_WORD(PIX_PER_WORD)
    ) u_frame_cnt (
        .clk       (M_AXI_ACLK),
        .rst       (M_AXI_ARESET),
        .load      (frame_start_s),
        .clear     (clear_s),
        .beat      (beat_s),
        .img_width (img_width),
        .img_height(img_height),
        .final_data(final_data_s),
        .sof       (sof)
    );

`ifdef MM2FIFO_RRESP_CHECK_EN
    logic rresp_err_r;

    // Sticky slave-error flag for the current frame; errored beats are still forwarded.
    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            rresp_err_r <= 1'b0;
        end else if (frame_start_s) begin
            rresp_err_r <= 1'b0;
        end else if (accept_s && M_AXI_RRESP[1]) begin
            rresp_err_r <= 1'b1;
        end else begin
            rresp_err_r <= rresp_err_r;
        end
    end

    assign rresp_err = rresp_err_r;
`endif

    assign unused_s = ^{M_AXI_RID, M_AXI_RRESP};

    assign resetting     = M_AXI_ARESET | draining_r | ~soft_resetn;
    assign frame_pulse   = frame_pulse_r;
    assign dout          = M_AXI_RDATA;
    assign wr_en         = beat_s;
    assign M_AXI_RREADY  = rready_s;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_ARADDR  = araddr_r;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLEN   = 8'(C_M_AXI_BURST_LEN - 1);
    assign M_AXI_ARSIZE  = 3'(clogb2(BYTES_PER_WORD));
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = AXI_CACHE_MOD;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARQOS   = 4'b0000;

endmodule
